// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the architectural PC, fetches one word at a time over req/ack,
// and presents the instruction to decode until the consumer accepts it.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr_count,
  output logic            fetch_fault
);

  // state  | meaning
  // IDLE   | one cycle after reset, no request
  // FETCH  | request outstanding at pc, waiting for imem_ack
  // ISSUED | instruction presented, waiting for consumer accept
  // FAULT  | misaligned redirect taken; parked until reset
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  state_t state_q, state_d;
  logic   accept;
  logic   misaligned;
  logic   fetch_done;

  assign accept     = (state_q == ISSUED) && !stall;
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
  assign fetch_done = (state_q == FETCH) && imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = ISSUED;
      ISSUED:  if (!stall) state_d = misaligned ? FAULT : FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      FETCH:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // The address is the PC itself, so it cannot move while a request is pending.
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);
  assign op        = instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_count <= '0;
      fetch_fault <= 1'b0;
    end else begin
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        instr_valid <= 1'b0;
        instr_count <= instr_count + 32'd1;
        pc          <= redirect ? redirect_target : pc_plus4;
        if (misaligned) fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: the bench plays instruction memory and consumer,
// and checks every presented instruction against a PC/count model of the program flow.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        fetch_fault;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .op(op),
    .pc(pc), .pc_plus4(pc_plus4),
    .instr_count(instr_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases on a negedge.
  task automatic do_reset(input logic ack_during);
    @(negedge clk);
    imem_ack   = ack_during;
    imem_rdata = $urandom;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",   imem_req,    0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr,       32'h0000_0013);
    chk("rst_op",    op,          7'd19);
    chk("rst_pc",    pc,          RESET_PC);
    chk("rst_count", instr_count, 0);
    chk("rst_fault", fetch_fault, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    rst_n    = 1'b1;
    m_pc     = RESET_PC;
    m_count  = 0;
    m_fault  = 1'b0;
    #1;
    chk("rel_req0",   imem_req,    0);
    chk("rel_valid0", instr_valid, 0);
    @(negedge clk);
    chk("rel_req1",  imem_req,  1);
    chk("rel_addr1", imem_addr, RESET_PC);
  endtask

  // One instruction: request, `waits` wait states, ack, `stalls` stalled cycles, accept.
  task automatic run_insn(input int waits, input int stalls, input bit redir,
                          input logic [31:0] tgt);
    int guard;
    logic [31:0] w;
    guard = 0;
    while (!imem_req && guard < 4) begin
      imem_ack = 1'b0;
      stall    = 1'($urandom);
      redirect = 1'($urandom);
      @(posedge clk); @(negedge clk);
      guard++;
    end
    chk("req_seen", imem_req,  1);
    chk("addr",     imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      stall      = 1'($urandom);
      redirect   = 1'($urandom);
      @(posedge clk); @(negedge clk);
      chk("req_hold",   imem_req,    1);
      chk("addr_hold",  imem_addr,   m_pc);
      chk("valid_wait", instr_valid, 0);
    end
    w          = mem_word(m_pc);
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(posedge clk); @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid",  instr_valid, 1);
    chk("instr",  instr,       w);
    chk("op",     op,          {25'd0, w[6:0]});
    chk("pc",     pc,          m_pc);
    chk("pc4",    pc_plus4,    m_pc + 32'd4);
    chk("req_lo", imem_req,    0);
    for (int i = 0; i < stalls; i++) begin
      stall           = 1'b1;
      redirect        = 1'($urandom);
      redirect_target = $urandom;
      @(posedge clk); @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr,       w);
      chk("stall_pc",    pc,          m_pc);
      chk("stall_count", instr_count, m_count);
      chk("stall_fault", fetch_fault, 0);
    end
    stall           = 1'b0;
    redirect        = redir;
    redirect_target = tgt;
    @(posedge clk); @(negedge clk);
    redirect = 1'b0;
    m_count  = m_count + 32'd1;
    if (redir) begin
      m_pc = tgt;
      if (tgt[1:0] != 2'b00) m_fault = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    chk("acc_count", instr_count, m_count);
    chk("acc_pc",    pc,          m_pc);
    chk("acc_valid", instr_valid, 0);
    chk("acc_fault", fetch_fault, m_fault);
    chk("acc_req",   imem_req,    m_fault ? 0 : 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] t;
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h00A0_0113;
    mem[32'h8] = 32'h0020_81B3;

    // Zero-wait stream of three instructions.
    do_reset(1'b0);
    run_insn(0, 0, 0, 0);
    run_insn(0, 0, 0, 0);
    run_insn(0, 0, 0, 0);
    chk("count3", instr_count, 3);
    chk("op_add", op, 7'd51);

    // Wait states, stall with ignored redirects, redirect, then misaligned redirect.
    do_reset(1'b0);
    run_insn(0, 0, 0, 0);
    run_insn(3, 0, 0, 0);
    run_insn(0, 5, 1, 32'h0000_0100);
    chk("redir_count", instr_count, 3);
    run_insn(1, 0, 1, 32'h0000_0102);
    for (int i = 0; i < 20; i++) begin
      imem_ack        = 1'($urandom);
      stall           = 1'($urandom);
      redirect        = 1'($urandom);
      redirect_target = $urandom;
      @(posedge clk); @(negedge clk);
      chk("fault_req",   imem_req,    0);
      chk("fault_valid", instr_valid, 0);
      chk("fault_stick", fetch_fault, 1);
    end
    imem_ack = 1'b0;

    // Reset while a fetch is outstanding, with the ack landing inside reset.
    do_reset(1'b0);
    run_insn(0, 0, 0, 0);
    do_reset(1'b1);
    chk("post_valid", instr_valid, 0);
    run_insn(0, 0, 0, 0);

    // Randomized program flow, including a PC wrap at the top of the address space.
    for (int i = 0; i < 40; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      if (i == 20)      run_insn($urandom_range(0, 3), $urandom_range(0, 2), 1, 32'hFFFF_FFFC);
      else if (i == 21) run_insn($urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
      else              run_insn($urandom_range(0, 3), $urandom_range(0, 2),
                                 ($urandom_range(0, 3) == 0), t);
      if (i == 21) chk("wrap_pc", pc, 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main control decoder.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake that tolerates wait states.
- Presents one instruction at a time, with its opcode field, to the decode/execute logic.
- Advances to PC+4 or to a redirect target (branch taken / JAL) when the consumer accepts the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- XLEN, 32, width of PC, address and instruction data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  XLEN  fetch address; equals pc, stable while imem_req is high.
- imem_ack  input  1  memory returns data this cycle; imem_rdata valid when high.
- imem_rdata  input  XLEN  fetched instruction word.
- stall  input  1  consumer cannot accept the presented instruction this cycle.
- redirect  input  1  taken branch or jump for the presented instruction.
- redirect_target  input  XLEN  next PC when redirect is high.
- instr_valid  output  1  instr/op/pc describe a live instruction.
- instr  output  XLEN  registered instruction word.
- op  output  7  instr[6:0]; combinational; feeds the decoder opcode input.
- pc  output  XLEN  address of the presented (or in-flight) instruction.
- pc_plus4  output  XLEN  pc + 4, combinational; used for the JAL link value.
- instr_count  output  32  number of instructions accepted since reset.
- fetch_fault  output  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, pc=RESET_PC.
  - instr=32'h0000_0013 (NOP, op=7'd19).
  - instr_valid=0, imem_req=0, instr_count=0, fetch_fault=0.
  - An outstanding memory request is abandoned; a late ack is ignored, because the FSM is in IDLE.
- FSM states: IDLE, FETCH, ISSUED, FAULT.
  - IDLE: imem_req=0. Unconditionally goes to FETCH next cycle, so the first request follows reset release by one cycle.
  - FETCH: imem_req=1, imem_addr=pc. With imem_ack=0, stay in FETCH; pc and addr are unchanged. With imem_ack=1, instr<=imem_rdata, instr_valid<=1, go to ISSUED. A same-cycle (zero-wait) ack is legal.
  - ISSUED: imem_req=0, instr_valid=1.
    - stall=1: hold everything; redirect is ignored.
    - stall=0 (accept): instr_count+=1 (wraps at 2^32), instr_valid<=0.
    - On accept with redirect=0: pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go to FETCH.
    - On accept with redirect=1 and redirect_target[1:0]==0: pc<=redirect_target, go to FETCH.
    - On accept with redirect=1 and redirect_target[1:0]!=0: pc<=redirect_target, fetch_fault<=1, go to FAULT.
  - FAULT: imem_req=0, instr_valid=0; all inputs ignored; exit only via rst_n.
- redirect and stall are sampled only in ISSUED; in other states they have no effect.
- instr keeps its last value while instr_valid=0; consumers must qualify with instr_valid.
- Throughput: at most one instruction per 2 cycles (FETCH+ack, then ISSUED). Each imem wait cycle adds one cycle.
- No combinational path from imem_ack/imem_rdata to any output except through registers. op is decoded from the registered instr only.

Test Plan:
- Reset with RESET_PC=32'h0000_0000 -> cycle 0 after release imem_req=0; cycle 1 imem_req=1, imem_addr=0; instr_valid=0, op=7'd19.
- Zero-wait memory returning 0x00500093, 0x00A00113, 0x002081B3, stall=0 -> instr_valid pulses every 2nd cycle; pc sequence 0,4,8; op sequence 19,19,51; instr_count=3.
- imem_ack delayed 3 cycles on fetch of pc=4 -> imem_req high and imem_addr=4 stable for 4 cycles; instr_valid stays 0 until the cycle after ack.
- Presented instruction at pc=8 with stall=1 for 5 cycles, then stall=0 and redirect=1, target=32'h0000_0100 -> instr/pc frozen during stall, redirect ignored; next imem_addr=0x100; instr_count increments exactly once.
- Accept with redirect=1, target=32'h0000_0102 -> fetch_fault=1, state FAULT, imem_req stays 0 for 20 cycles; rst_n low clears fault and pc returns to RESET_PC.
- rst_n asserted mid-FETCH with ack arriving during reset -> outputs at reset values immediately (asynchronously); ack ignored; first post-reset imem_addr=RESET_PC.
